// File: rtl/jk_bank_arbiter.sv
// Bank of N_BITS JK flip-flops that two requesters share under round-robin arbitration.
// Each command runs IDLE -> EXEC -> ACK. q changes at EXEC and gnt pulses for the ACK cycle.
module jk_bank_arbiter #(
    parameter int unsigned N_BITS = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [1:0]        op0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    input  logic              req1,
    input  logic [1:0]        op1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic              busy,
    output logic [N_BITS-1:0] q,
    output logic [N_BITS-1:0] qb
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        ACK
    } state_t;

    state_t            state;
    logic              last;
    logic              win;
    logic              win_next;
    logic [1:0]        lop;
    logic [ADDR_W-1:0] laddr;
    logic [N_BITS-1:0] q_next;

    // When both requesters are active, the one not served last wins. Otherwise the only active requester wins.
    always_comb begin
        win_next = (req0 && req1) ? ~last : req1;
    end

    // An address of N_BITS or more matches no bit, so the bank holds its value.
    always_comb begin
        q_next = q;
        for (int unsigned i = 0; i < N_BITS; i++) begin
            if (laddr == ADDR_W'(i)) begin
                case (lop)
                    2'b01:   q_next[i] = 1'b0;
                    2'b10:   q_next[i] = 1'b1;
                    2'b11:   q_next[i] = ~q[i];
                    default: q_next[i] = q[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            last  <= 1'b1;
            win   <= 1'b0;
            lop   <= '0;
            laddr <= '0;
            q     <= '0;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        win   <= win_next;
                        last  <= win_next;
                        lop   <= win_next ? op1 : op0;
                        laddr <= win_next ? addr1 : addr0;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    q     <= q_next;
                    gnt0  <= ~win;
                    gnt1  <= win;
                    state <= ACK;
                end
                default: begin
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign qb   = ~q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter: an 8-bit bank, plus a 6-bit bank for out-of-range addresses.
// Expected q values are hand-computed and kept in qe.
module tb_jk_bank_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [1:0] op0 = '0, op1 = '0;
    logic [2:0] addr0 = '0, addr1 = '0;
    logic       gnt0, gnt1, busy;
    logic [7:0] q, qb;
    logic       gnt0_6, gnt1_6, busy_6;
    logic [5:0] q_6, qb_6;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [7:0]  qe = '0;
    bit          sel6 = 1'b0;

    always #5 clk = ~clk;

    jk_bank_arbiter #(.N_BITS(8), .ADDR_W(3)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .op0(op0), .addr0(addr0), .gnt0(gnt0),
        .req1(req1), .op1(op1), .addr1(addr1), .gnt1(gnt1),
        .busy(busy), .q(q), .qb(qb)
    );

    jk_bank_arbiter #(.N_BITS(6), .ADDR_W(3)) dut6 (
        .clk(clk), .reset(reset),
        .req0(req0), .op0(op0), .addr0(addr0), .gnt0(gnt0_6),
        .req1(req1), .op1(op1), .addr1(addr1), .gnt1(gnt1_6),
        .busy(busy_6), .q(q_6), .qb(qb_6)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then sample every output against the expected values.
    task automatic step(input string tag, input bit eb, input bit eg0, input bit eg1);
        logic [7:0] want_qb;
        @(posedge clk);
        #1;
        want_qb = ~qe;
        if (sel6) begin
            check({tag, "_busy"}, 32'(busy_6), 32'(eb));
            check({tag, "_gnt0"}, 32'(gnt0_6), 32'(eg0));
            check({tag, "_gnt1"}, 32'(gnt1_6), 32'(eg1));
            check({tag, "_q"},    32'(q_6),    32'(qe[5:0]));
            check({tag, "_qb"},   32'(qb_6),   32'(want_qb[5:0]));
        end else begin
            check({tag, "_busy"}, 32'(busy), 32'(eb));
            check({tag, "_gnt0"}, 32'(gnt0), 32'(eg0));
            check({tag, "_gnt1"}, 32'(gnt1), 32'(eg1));
            check({tag, "_q"},    32'(q),    32'(qe));
            check({tag, "_qb"},   32'(qb),   32'(want_qb));
        end
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        qe = '0;
        step({tag, "_r1"}, 0, 0, 0);
        step({tag, "_r2"}, 0, 0, 0);
        reset = 1'b0;
    endtask

    // One complete handshake from a single requester. qn is the q value expected after EXEC.
    task automatic cmd(input string tag, input bit r, input logic [1:0] o,
                       input logic [2:0] a, input logic [7:0] qn);
        if (r) begin
            req1 = 1'b1; op1 = o; addr1 = a;
        end else begin
            req0 = 1'b1; op0 = o; addr0 = a;
        end
        step({tag, "_e0"}, 1, 0, 0);
        qe = qn;
        step({tag, "_e1"}, 1, !r, r);
        req0 = 1'b0;
        req1 = 1'b0;
        step({tag, "_e2"}, 0, 0, 0);
    endtask

    initial begin
        do_reset("rst");

        cmd("set3", 0, 2'b10, 3'd3, 8'h08);

        // Contention test. Requester 1 is served first, so requester 0 wins the next tie.
        do_reset("rst_c");
        cmd("pre1", 1, 2'b10, 3'd3, 8'h08);
        req0 = 1'b1; op0 = 2'b11; addr0 = 3'd3;
        req1 = 1'b1; op1 = 2'b10; addr1 = 3'd7;
        step("c_e0", 1, 0, 0);
        qe = 8'h00;
        step("c_e1", 1, 1, 0);
        req0 = 1'b0;
        step("c_e2", 0, 0, 0);
        step("c_e0b", 1, 0, 0);
        qe = 8'h80;
        step("c_e1b", 1, 0, 1);
        req1 = 1'b0;
        step("c_e2b", 0, 0, 0);
        req0 = 1'b1; op0 = 2'b10; addr0 = 3'd1;
        req1 = 1'b1; op1 = 2'b01; addr1 = 3'd7;
        step("c2_e0", 1, 0, 0);
        qe = 8'h82;
        step("c2_e1", 1, 1, 0);
        req0 = 1'b0;
        step("c2_e2", 0, 0, 0);
        step("c2_e0b", 1, 0, 0);
        qe = 8'h02;
        step("c2_e1b", 1, 0, 1);
        req1 = 1'b0;
        step("c2_e2b", 0, 0, 0);

        // Toggle and reset commands on single bits.
        do_reset("rst_t");
        cmd("tog0a", 0, 2'b11, 3'd0, 8'h01);
        cmd("tog0b", 1, 2'b11, 3'd0, 8'h00);
        cmd("set5",  0, 2'b10, 3'd5, 8'h20);
        cmd("clr5",  1, 2'b01, 3'd5, 8'h00);

        // req drops right after it is sampled. The transaction still completes.
        req1 = 1'b1; op1 = 2'b10; addr1 = 3'd4;
        step("drop_e0", 1, 0, 0);
        req1 = 1'b0; op1 = 2'b00; addr1 = 3'd0;
        qe = 8'h10;
        step("drop_e1", 1, 0, 1);
        step("drop_e2", 0, 0, 0);

        // Reset asserted at E1 discards the pending command, and no gnt pulses.
        do_reset("rst_m");
        req0 = 1'b1; op0 = 2'b10; addr0 = 3'd2;
        step("mid_e0", 1, 0, 0);
        reset = 1'b1;
        step("mid_e1", 0, 0, 0);
        reset = 1'b0;
        req0 = 1'b0;
        step("mid_after", 0, 0, 0);

        // 6-bit bank: out-of-range address and hold opcode.
        sel6 = 1'b1;
        do_reset("rst6");
        cmd("s6_set5", 0, 2'b10, 3'd5, 8'h20);
        cmd("s6_oor7", 0, 2'b10, 3'd7, 8'h20);
        cmd("s6_oor6", 1, 2'b11, 3'd6, 8'h20);
        cmd("s6_hold", 1, 2'b00, 3'd5, 8'h20);
        sel6 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jk_bank_arbiter.md
Name: jk_bank_arbiter

Overview:
- Shared bank of N_BITS JK flip-flops, arbitrated between two requesters.
- Each requester issues one command per transaction, targeting a single bit: hold, reset (J=0,K=1), set (J=1,K=0) or toggle (J=1,K=1).
- Arbitration is round-robin; a three-state FSM sequences the apply and the grant.
- Used as the software/FSM-controlled flag register where several control blocks share JK-style state bits.

Parameters:
- N_BITS, 8, number of JK flip-flops in the bank (2..32).
- ADDR_W, 3, width of bit-select address; must satisfy 2**ADDR_W >= N_BITS.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 command request.
- op0  input  2  requester 0 opcode: 00 hold, 01 reset bit, 10 set bit, 11 toggle bit.
- addr0  input  ADDR_W  requester 0 target bit index.
- gnt0  output  1  one-cycle completion pulse to requester 0.
- req1  input  1  requester 1 command request.
- op1  input  2  requester 1 opcode, same encoding as op0.
- addr1  input  ADDR_W  requester 1 target bit index.
- gnt1  output  1  one-cycle completion pulse to requester 1.
- busy  output  1  high whenever the FSM is not in IDLE.
- q  output  N_BITS  flip-flop bank state.
- qb  output  N_BITS  bitwise complement of q, always exactly ~q.

Behaviour:
- Reset values: q=0, qb=all ones, gnt0=0, gnt1=0, busy=0, FSM=IDLE, last-served pointer=1 (so requester 0 has priority first).
- Reset is checked before every other action on every edge.
- FSM states and transitions:
  - IDLE: at edge E0, if req0 or req1 is high, arbitrate, latch the winner's op and addr, update the last-served pointer to the winner, go to EXEC. Otherwise stay in IDLE.
  - EXEC: at edge E1, apply the latched command to q[addr] using JK semantics, register gnt of the winner to 1, go to ACK.
  - ACK: gnt is high for this cycle only. At edge E2, gnt returns to 0 and the FSM goes to IDLE. No arbitration happens at E2.
- Arbitration:
  - Only one requester high: that requester wins.
  - Both high: the requester not equal to last-served wins.
- Latency and throughput:
  - The command is sampled at E0; q shows the new value and gnt is high between E1 and E2.
  - Maximum throughput is one command per 3 cycles.
- Requester handshake rules:
  - Hold req, op and addr stable from assertion until gnt is seen.
  - op and addr are don't-care after E0, because they are latched.
  - If req is still high at the first IDLE edge after the gnt cycle, it is a new request.
- JK semantics on the selected bit:
  - 00: no change.
  - 01: bit becomes 0.
  - 10: bit becomes 1.
  - 11: bit inverts.
  - All unselected bits hold.
- Boundary conditions:
  - op=00: full handshake, gnt still pulses, q unchanged.
  - addr >= N_BITS: command ignored, gnt still pulses, q unchanged.
  - reset high at any edge (including E1 or E2): FSM goes to IDLE, pending command discarded, no gnt pulse, q cleared.
  - A requester deasserting req before gnt while the FSM is past IDLE: the transaction still completes and gnt still pulses.
  - gnt0 and gnt1 are never high in the same cycle.

Test Plan:
1. Reset: assert reset for 2 cycles -> q=8'h00, qb=8'hFF, gnt0=gnt1=0, busy=0.
2. Single set: req0=1, op0=10, addr0=3 sampled at E0 -> busy=1 from E0; at E1 q=8'h08 and gnt0=1 for exactly one cycle; busy=0 after E2.
3. Contention: from reset, req0 (op 11, addr 3) and req1 (op 10, addr 7) both held, q=8'h08.
   - gnt0 first, then q=8'h00.
   - Then gnt1 three cycles later, then q=8'h80.
   - Repeat with both held again -> gnt0 wins, since requester 1 was last served.
4. Toggle and reset: two toggles on addr 0 -> q[0] goes 0→1→0. Set addr 5, then op 01 on addr 5 -> q[5]=0. Check qb==~q every cycle.
5. Reset mid-operation: reset asserted at E1 of a set on addr 2 -> q stays 8'h00, no gnt pulse, FSM in IDLE next cycle.
6. Out of range and hold: with N_BITS=6, ADDR_W=3:
   - addr=7 set -> gnt pulses, q unchanged.
   - op=00 -> gnt pulses, q unchanged.
